// File: rtl/seg_pkg.sv
// Shared constants and types for the 7-segment display blocks: blanking
// values, the hex-to-segment table and the display buffer layout.
package seg_pkg;

  localparam int NUM_DIGITS = 8;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [7:0] AN_OFF    = 8'hFF;

  // Segment codes {g,f,e,d,c,b,a}, active-low; entry n sits at bits [7n+6:7n].
  localparam logic [16*7-1:0] HEX_SEG_TABLE = {
    7'b0001110,  // F
    7'b0000110,  // E
    7'b0100001,  // d
    7'b1000110,  // C
    7'b0000011,  // b
    7'b0001000,  // A
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

  typedef struct packed {
    logic [31:0] data;
    logic [7:0]  dp;
    logic [7:0]  en;
  } disp_buf_t;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    return HEX_SEG_TABLE[int'(nib) * 7 +: 7];
  endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational hex nibble to active-low 7-segment code, shared by the
// display blocks.
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  always_comb begin
    seg = hex_to_seg(nib);
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Scan scheduler for an 8-digit common-anode display: per-slot blanking gap,
// double-buffered content loaded by valid/ready and swapped only at frame ends.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int TICK_DIV  = 100000,
  parameter int BLANK_CYC = 1000
)
(
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] data_in,
  input  logic [7:0]  dp_in,
  input  logic [7:0]  digit_en,
  input  logic        load_valid,
  output logic        load_ready,
  output logic        frame_start,
  output logic [6:0]  C,
  output logic        DP,
  output logic [7:0]  AN
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] SLOT_LAST = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYC);
  localparam logic [2:0]    DIG_LAST  = 3'(NUM_DIGITS - 1);

  logic [CW-1:0] slot_cnt_q, slot_cnt_d;
  logic [2:0]    dig_q, dig_d;
  disp_buf_t     active_q, active_d;
  disp_buf_t     pend_q, pend_d;
  logic          pend_full_q, pend_full_d;
  logic          load_ready_q, load_ready_d;
  logic          frame_start_q, frame_start_d;
  logic [7:0]    an_q, an_d;
  logic [6:0]    c_q, c_d;
  logic          dp_q, dp_d;

  logic          at_slot_end;
  logic          at_fb;
  logic          load_fire;
  logic          in_blank;
  logic [3:0]    cur_nib;
  logic [6:0]    cur_seg;

  // Slot and digit counters run freely; there is no idle state.
  always_comb begin
    at_slot_end = (slot_cnt_q == SLOT_LAST);
    at_fb       = at_slot_end && (dig_q == DIG_LAST);
    slot_cnt_d  = at_slot_end ? '0 : slot_cnt_q + 1'b1;
    dig_d       = at_slot_end ? dig_q + 3'd1 : dig_q;
  end

  // Valid/ready: a transfer happens in any cycle where load_valid and
  // load_ready are both high; load_ready is high exactly while the pending
  // buffer is empty, and the source holds its data until that cycle.
  // Loads landing in the frame-boundary cycle only fill pending, so the
  // frame starting next never sees them.
  always_comb begin
    load_fire   = load_valid && load_ready_q;
    active_d    = active_q;
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    if (at_fb && pend_full_q) begin
      active_d    = pend_q;
      pend_full_d = 1'b0;
    end
    if (load_fire) begin
      pend_d.data = data_in;
      pend_d.dp   = dp_in;
      pend_d.en   = digit_en;
      pend_full_d = 1'b1;
    end
    load_ready_d  = ~pend_full_d;
    frame_start_d = at_fb;
  end

  always_comb begin
    cur_nib = active_q.data[{dig_q, 2'b00} +: 4];
  end

  seg_hex_decode u_hex_decode (
    .nib (cur_nib),
    .seg (cur_seg)
  );

  // Anode and segment registers update together so a lit anode never
  // pairs with a stale segment code.
  always_comb begin
    in_blank = (slot_cnt_q < BLANK_END);
    an_d     = AN_OFF;
    c_d      = SEG_BLANK;
    dp_d     = 1'b1;
    if (!in_blank && active_q.en[dig_q]) begin
      an_d = ~(8'h01 << dig_q);
      c_d  = cur_seg;
      dp_d = ~active_q.dp[dig_q];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      slot_cnt_q    <= '0;
      dig_q         <= '0;
      active_q      <= '0;
      pend_q        <= '0;
      pend_full_q   <= 1'b0;
      load_ready_q  <= 1'b1;
      frame_start_q <= 1'b0;
      an_q          <= AN_OFF;
      c_q           <= SEG_BLANK;
      dp_q          <= 1'b1;
    end else begin
      slot_cnt_q    <= slot_cnt_d;
      dig_q         <= dig_d;
      active_q      <= active_d;
      pend_q        <= pend_d;
      pend_full_q   <= pend_full_d;
      load_ready_q  <= load_ready_d;
      frame_start_q <= frame_start_d;
      an_q          <= an_d;
      c_q           <= c_d;
      dp_q          <= dp_d;
    end
  end

  assign load_ready  = load_ready_q;
  assign frame_start = frame_start_q;
  assign AN          = an_q;
  assign C           = c_q;
  assign DP          = dp_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl with TICK_DIV=8, BLANK_CYC=2.
module tb_seg_scan_ctrl;

  localparam int TICK_DIV  = 8;
  localparam int BLANK_CYC = 2;
  localparam int FRAME     = 8 * TICK_DIV;

  localparam logic [31:0] A_DATA = 32'h0F1E2D3C;
  localparam logic [7:0]  A_DP   = 8'h81;
  localparam logic [7:0]  A_EN   = 8'hFF;
  localparam logic [31:0] B_DATA = 32'hA5A55A5A;
  localparam logic [7:0]  B_DP   = 8'h3C;
  localparam logic [7:0]  B_EN   = 8'hF0;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] data_in;
  logic [7:0]  dp_in;
  logic [7:0]  digit_en;
  logic        load_valid;
  logic        load_ready;
  logic        frame_start;
  logic [6:0]  C;
  logic        DP;
  logic [7:0]  AN;

  int tests_run = 0;
  int fails     = 0;
  logic [15:0] exp_q[$];

  seg_scan_ctrl #(.TICK_DIV(TICK_DIV), .BLANK_CYC(BLANK_CYC)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .data_in     (data_in),
    .dp_in       (dp_in),
    .digit_en    (digit_en),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .frame_start (frame_start),
    .C           (C),
    .DP          (DP),
    .AN          (AN)
  );

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [6:0] ref_seg(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;
      4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;
      4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  // Expected {AN,C,DP} produced while the counters sit at frame position p.
  function automatic logic [15:0] ref_pins(input logic [31:0] data, input logic [7:0] dp,
                                           input logic [7:0] en, input int p);
    int d;
    int s;
    logic [7:0] an;
    logic [3:0] nib;
    d = p / TICK_DIV;
    s = p % TICK_DIV;
    if (s < BLANK_CYC || en[d] == 1'b0) return {8'hFF, 7'h7F, 1'b1};
    an    = 8'hFF;
    an[d] = 1'b0;
    nib   = data[4*d +: 4];
    return {an, ref_seg(nib), ~dp[d]};
  endfunction

  // Pins lag counters by one cycle, so cycles 1..64 after frame_start show positions 0..63.
  function automatic void push_frame(input logic [31:0] data, input logic [7:0] dp,
                                     input logic [7:0] en);
    for (int p = 0; p < FRAME; p++) exp_q.push_back(ref_pins(data, dp, en, p));
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive_load(input logic [31:0] d, input logic [7:0] p, input logic [7:0] e);
    data_in    = d;
    dp_in      = p;
    digit_en   = e;
    load_valid = 1'b1;
  endtask

  task automatic drop_load();
    load_valid = 1'b0;
    data_in    = $urandom();
    dp_in      = 8'($urandom_range(0, 255));
    digit_en   = 8'($urandom_range(0, 255));
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int n;
    logic [15:0] got, exp;
    RST = 1'b1;
    load_valid = 1'b0;
    data_in = '0; dp_in = '0; digit_en = '0;
    repeat (2) tick();
    RST = 1'b0;
    repeat (20) tick();
    drive_load(32'h11111111, 8'hFF, 8'hFF);
    tick();
    drop_load();
    tests_run++;
    if (load_ready !== 1'b0) begin
      fails++; $display("FAIL reset_preload_ready got=%b exp=0", load_ready);
    end
    repeat (5) tick();
    RST = 1'b1;
    repeat (3) tick();
    RST = 1'b0;
    tests_run++;
    if ({AN, C, DP, load_ready, frame_start} !== {8'hFF, 7'h7F, 1'b1, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL reset_values got AN=%h C=%h DP=%b rdy=%b fs=%b exp AN=ff C=7f DP=1 rdy=1 fs=0",
               AN, C, DP, load_ready, frame_start);
    end
    for (n = 1; n <= 200; n++) begin
      tick();
      if (frame_start === 1'b1) break;
    end
    tests_run++;
    if (n != FRAME) begin
      fails++; $display("FAIL reset_first_frame_start got=%0d exp=%0d", n, FRAME);
    end
    // Discarded pending content must not appear in the first frame.
    push_frame(32'h0, 8'h0, 8'h0);
    for (int j = 1; j <= FRAME; j++) begin
      tick();
      got = {AN, C, DP};
      exp = exp_q.pop_front();
      tests_run++;
      if (got !== exp) begin
        fails++; $display("FAIL reset_blank_frame j=%0d got=%h exp=%h", j, got, exp);
      end
    end
  endtask

  task automatic test_load_apply();
    int n;
    logic [15:0] got, exp;
    repeat (3 * TICK_DIV) tick();
    tests_run++;
    if (load_ready !== 1'b1) begin
      fails++; $display("FAIL load_ready_idle got=%b exp=1", load_ready);
    end
    drive_load(32'h76543210, 8'h01, 8'hFF);
    tick();
    drop_load();
    tests_run++;
    if (load_ready !== 1'b0) begin
      fails++; $display("FAIL load_ready_fall got=%b exp=0", load_ready);
    end
    n = 0;
    while (frame_start !== 1'b1 && n < 100) begin
      tests_run++;
      if (AN !== 8'hFF) begin
        fails++; $display("FAIL load_early_visible got AN=%h exp AN=ff", AN);
      end
      tick();
      n++;
    end
    tests_run++;
    if (frame_start !== 1'b1 || load_ready !== 1'b1) begin
      fails++; $display("FAIL load_fb_reach got fs=%b rdy=%b exp fs=1 rdy=1", frame_start, load_ready);
    end
    push_frame(32'h76543210, 8'h01, 8'hFF);
    for (int j = 1; j <= FRAME; j++) begin
      tick();
      got = {AN, C, DP};
      exp = exp_q.pop_front();
      tests_run++;
      if (got !== exp) begin
        fails++; $display("FAIL load_apply j=%0d got=%h exp=%h", j, got, exp);
      end
    end
  endtask

  task automatic test_backpressure();
    int n;
    logic [15:0] got, exp;
    tests_run++;
    if (load_ready !== 1'b1) begin
      fails++; $display("FAIL bp_ready_start got=%b exp=1", load_ready);
    end
    drive_load(A_DATA, A_DP, A_EN);
    tick();
    drive_load(B_DATA, B_DP, B_EN);
    n = 0;
    while (frame_start !== 1'b1 && n < 100) begin
      tests_run++;
      if (load_ready !== 1'b0) begin
        fails++; $display("FAIL bp_ready_held got=%b exp=0", load_ready);
      end
      tick();
      n++;
    end
    tests_run++;
    if (frame_start !== 1'b1 || load_ready !== 1'b1) begin
      fails++; $display("FAIL bp_fb_release got fs=%b rdy=%b exp fs=1 rdy=1", frame_start, load_ready);
    end
    push_frame(A_DATA, A_DP, A_EN);
    push_frame(B_DATA, B_DP, B_EN);
    for (int j = 1; j <= 2 * FRAME; j++) begin
      tick();
      if (j == 1) begin
        tests_run++;
        if (load_ready !== 1'b0) begin
          fails++; $display("FAIL bp_b_accept got rdy=%b exp=0", load_ready);
        end
        drop_load();
      end
      got = {AN, C, DP};
      exp = exp_q.pop_front();
      tests_run++;
      if (got !== exp) begin
        fails++; $display("FAIL bp_frames j=%0d got=%h exp=%h", j, got, exp);
      end
    end
  endtask

  task automatic test_load_on_fb();
    logic [15:0] got, exp;
    repeat (FRAME - 1) tick();
    tests_run++;
    if (frame_start !== 1'b0 || load_ready !== 1'b1) begin
      fails++; $display("FAIL fb_pre got fs=%b rdy=%b exp fs=0 rdy=1", frame_start, load_ready);
    end
    drive_load(32'h89ABCDEF, 8'hF0, 8'hFF);
    tick();
    drop_load();
    tests_run++;
    if (frame_start !== 1'b1 || load_ready !== 1'b0) begin
      fails++; $display("FAIL fb_transfer got fs=%b rdy=%b exp fs=1 rdy=0", frame_start, load_ready);
    end
    push_frame(B_DATA, B_DP, B_EN);
    push_frame(32'h89ABCDEF, 8'hF0, 8'hFF);
    for (int j = 1; j <= 2 * FRAME; j++) begin
      tick();
      got = {AN, C, DP};
      exp = exp_q.pop_front();
      tests_run++;
      if (got !== exp) begin
        fails++; $display("FAIL fb_frames j=%0d got=%h exp=%h", j, got, exp);
      end
    end
  endtask

  task automatic test_digit_mask();
    int n;
    logic [15:0] got, exp;
    drive_load(32'h13579BDF, 8'h5A, 8'b10100101);
    tick();
    drop_load();
    n = 0;
    while (frame_start !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    tests_run++;
    if (frame_start !== 1'b1) begin
      fails++; $display("FAIL mask_wait_fs got=%b exp=1", frame_start);
    end
    push_frame(32'h13579BDF, 8'h5A, 8'b10100101);
    for (int j = 1; j <= FRAME; j++) begin
      tick();
      got = {AN, C, DP};
      exp = exp_q.pop_front();
      tests_run++;
      if (got !== exp) begin
        fails++; $display("FAIL mask_frame j=%0d got=%h exp=%h", j, got, exp);
      end
      tests_run++;
      if ((AN & 8'h5A) !== 8'h5A) begin
        fails++; $display("FAIL mask_anode j=%0d got AN=%h exp bits 1,3,4,6 high", j, AN);
      end
      tests_run++;
      if (frame_start !== (j == FRAME)) begin
        fails++; $display("FAIL mask_spacing j=%0d got fs=%b exp=%b", j, frame_start, (j == FRAME));
      end
    end
  endtask

  task automatic test_wrap_sweep();
    int n;
    logic [15:0] got, exp;
    drive_load(32'hFEDCBA98, 8'h00, 8'hFF);
    tick();
    drop_load();
    n = 0;
    while (frame_start !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    tests_run++;
    if (frame_start !== 1'b1) begin
      fails++; $display("FAIL sweep_wait_fs got=%b exp=1", frame_start);
    end
    push_frame(32'hFEDCBA98, 8'h00, 8'hFF);
    push_frame(32'hFEDCBA98, 8'h00, 8'hFF);
    for (int j = 1; j <= 2 * FRAME; j++) begin
      tick();
      got = {AN, C, DP};
      exp = exp_q.pop_front();
      tests_run++;
      if (got !== exp) begin
        fails++; $display("FAIL sweep_frames j=%0d got=%h exp=%h", j, got, exp);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_load_apply();
    test_backpressure();
    test_load_on_fb();
    test_digit_mask();
    test_wrap_sweep();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
